// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the registered EX-stage ALU.
// - aluOp_e   : 5-bit AluOp encodings. Values not listed are undefined ops.
// - mdState_e : state encodings of the iterative multiply/divide engine.
// - isMulDivOp: true for ops handled by the iterative engine.
package alu_muldiv_seq_pkg;

  localparam int ALU_OP_W = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD   = 5'd0,
    OP_ADDU  = 5'd1,
    OP_SUB   = 5'd2,
    OP_SUBU  = 5'd3,
    OP_AND   = 5'd4,
    OP_OR    = 5'd5,
    OP_XOR   = 5'd6,
    OP_NOR   = 5'd7,
    OP_SLL   = 5'd8,
    OP_SRL   = 5'd9,
    OP_SRA   = 5'd10,
    OP_SLT   = 5'd11,
    OP_SLTU  = 5'd12,
    OP_LINK  = 5'd13,
    OP_MUL   = 5'd14,
    OP_MULT  = 5'd15,
    OP_MULTU = 5'd16,
    OP_DIV   = 5'd17,
    OP_DIVU  = 5'd18,
    OP_MFHI  = 5'd19,
    OP_MFLO  = 5'd20
  } aluOp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdState_e;

  function automatic logic isMulDivOp(input logic [ALU_OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Pipeline-side bus of the EX-stage ALU.
// master: decode/issue side (drives operands, op, write-back request).
// slave : the ALU (drives busy, result, write-back and overflow).
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 5
);
  logic             in_valid;
  logic             flush;
  logic [OP_W-1:0]  AluOp;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic [WIDTH-1:0] linkAddr;
  logic             RegWriteEn_i;
  logic [4:0]       RegWriteAddr_i;
  logic             busy_o;
  logic             out_valid;
  logic             RegWriteEn_o;
  logic [4:0]       RegWriteAddr_o;
  logic [WIDTH-1:0] RegWriteData_o;
  logic             overflow_o;

  modport master (
    output in_valid, flush, AluOp, num1, num2, linkAddr, RegWriteEn_i, RegWriteAddr_i,
    input  busy_o, out_valid, RegWriteEn_o, RegWriteAddr_o, RegWriteData_o, overflow_o
  );

  modport slave (
    input  in_valid, flush, AluOp, num1, num2, linkAddr, RegWriteEn_i, RegWriteAddr_i,
    output busy_o, out_valid, RegWriteEn_o, RegWriteAddr_o, RegWriteData_o, overflow_o
  );
endinterface

// File: rtl/alu_muldiv_seq_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU engine (seq_muldiv_unit). Works on operand
// magnitudes, one bit per cycle, and applies signs in the FIX cycle.
// Ports: clk, rstn; start/isSigned/isDiv/flush control; opA (multiplicand or
// dividend), opB (multiplier or divisor); busy, done (FIX cycle, not flushed),
// hi/lo final result valid while done is high.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start
// ST_MUL  | radix-2 shift-add, WIDTH iterations
// ST_DIV  | restoring division, WIDTH iterations
// ST_FIX  | sign fix-up; result presented to the HI/LO registers
module alu_muldiv_seq_muldiv
  import alu_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             isSigned,
  input  logic             isDiv,
  input  logic             flush,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  mdState_e         state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   accHi;     // partial product high half / remainder
  logic [WIDTH-1:0] accLo;     // multiplier bits / dividend bits -> quotient
  logic [WIDTH-1:0] operand;   // multiplicand or divisor magnitude
  logic             isDivOp;
  logic             negQ;
  logic             negR;
  logic             zeroDiv;

  logic             aNeg;
  logic             bNeg;
  logic [WIDTH-1:0] aMag;
  logic [WIDTH-1:0] bMag;

  assign aNeg = isSigned & opA[WIDTH-1];
  assign bNeg = isSigned & opB[WIDTH-1];
  assign aMag = aNeg ? -opA : opA;
  assign bMag = bNeg ? -opB : opB;

  logic [WIDTH:0]   mulAdd;
  logic [2*WIDTH:0] mulShift;
  assign mulAdd   = accLo[0] ? (accHi + {1'b0, operand}) : accHi;
  assign mulShift = {mulAdd, accLo} >> 1;

  // One extra bit on the trial subtraction so the borrow is reliable even
  // when the shifted remainder uses its top bit.
  logic [WIDTH:0]   divShift;
  logic [WIDTH+1:0] divDiff;
  logic             divBorrow;
  assign divShift  = {accHi[WIDTH-1:0], accLo[WIDTH-1]};
  assign divDiff   = {1'b0, divShift} - {2'b00, operand};
  assign divBorrow = divDiff[WIDTH+1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      accHi   <= '0;
      accLo   <= '0;
      operand <= '0;
      isDivOp <= 1'b0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      zeroDiv <= 1'b0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt     <= CNT_W'(WIDTH - 1);
            isDivOp <= isDiv;
            negQ    <= aNeg ^ bNeg;
            negR    <= aNeg;
            zeroDiv <= 1'b0;
            if (isDiv && (opB == '0)) begin
              // Divide by zero: no iterations, raw dividend goes to HI.
              state   <= ST_FIX;
              zeroDiv <= 1'b1;
              accHi   <= {1'b0, opA};
              accLo   <= '1;
            end else if (isDiv) begin
              state   <= ST_DIV;
              accHi   <= '0;
              accLo   <= aMag;
              operand <= bMag;
            end else begin
              state   <= ST_MUL;
              accHi   <= '0;
              accLo   <= bMag;
              operand <= aMag;
            end
          end
        end
        ST_MUL: begin
          {accHi, accLo} <= mulShift;
          if (cnt == '0) state <= ST_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        ST_DIV: begin
          accHi <= divBorrow ? divShift : divDiff[WIDTH:0];
          accLo <= {accLo[WIDTH-2:0], ~divBorrow};
          if (cnt == '0) state <= ST_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  // Combinational so HI/LO and out_valid land on the same edge that leaves FIX.
  assign done = (state == ST_FIX) & ~flush;

  logic [2*WIDTH-1:0] prodMag;
  logic [2*WIDTH-1:0] prodFix;
  assign prodMag = {accHi[WIDTH-1:0], accLo};
  assign prodFix = negQ ? -prodMag : prodMag;

  always_comb begin
    hi = prodFix[2*WIDTH-1:WIDTH];
    lo = prodFix[WIDTH-1:0];
    if (isDivOp) begin
      if (zeroDiv) begin
        hi = accHi[WIDTH-1:0];
        lo = accLo;
      end else begin
        // Remainder follows the dividend sign; MIN / -1 falls out as MIN, 0.
        lo = negQ ? -accLo : accLo;
        hi = negR ? -accHi[WIDTH-1:0] : accHi[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Registered EX-stage ALU with internal HI/LO and an iterative MULT/DIV engine.
// Ports: clk, rstn (async active-low); bus (slave modport) carrying in_valid,
// flush, AluOp, num1, num2, linkAddr, RegWriteEn_i, RegWriteAddr_i in and
// busy_o, out_valid, RegWriteEn_o, RegWriteAddr_o, RegWriteData_o, overflow_o out.
// Single-cycle ops have latency 1; MULT/DIV hold busy_o for WIDTH+1 cycles.
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int OP_W    = 5
) (
  input logic             clk,
  input logic             rstn,
  alu_muldiv_seq_if.slave bus
);

  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;

  logic busy;
  logic accept;
  logic isMulDiv;
  logic mdDone;
  logic [WIDTH-1:0] mdHi;
  logic [WIDTH-1:0] mdLo;

  assign isMulDiv   = isMulDivOp(bus.AluOp);
  assign accept     = bus.in_valid & ~busy & ~bus.flush;
  assign bus.busy_o = busy;

  alu_muldiv_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rstn     (rstn),
    .start    (accept & isMulDiv),
    .isSigned ((bus.AluOp == OP_MULT) || (bus.AluOp == OP_DIV)),
    .isDiv    ((bus.AluOp == OP_DIV) || (bus.AluOp == OP_DIVU)),
    .flush    (bus.flush),
    .opA      (bus.num1),
    .opB      (bus.num2),
    .busy     (busy),
    .done     (mdDone),
    .hi       (mdHi),
    .lo       (mdLo)
  );

  logic [WIDTH:0]     sumAdd;
  logic [WIDTH:0]     sumSub;
  logic [SHAMT_W-1:0] shamt;
  assign sumAdd = {bus.num1[WIDTH-1], bus.num1} + {bus.num2[WIDTH-1], bus.num2};
  assign sumSub = {bus.num1[WIDTH-1], bus.num1} - {bus.num2[WIDTH-1], bus.num2};
  assign shamt  = bus.num1[SHAMT_W-1:0];

  logic [WIDTH-1:0] scData;
  logic             scOvf;
  logic             scWen;

  always_comb begin
    scData = '0;
    scOvf  = 1'b0;
    scWen  = bus.RegWriteEn_i;
    case (bus.AluOp)
      OP_ADD: begin
        scData = sumAdd[WIDTH-1:0];
        scOvf  = sumAdd[WIDTH] ^ sumAdd[WIDTH-1];
      end
      OP_SUB: begin
        scData = sumSub[WIDTH-1:0];
        scOvf  = sumSub[WIDTH] ^ sumSub[WIDTH-1];
      end
      OP_ADDU: scData = bus.num1 + bus.num2;
      OP_SUBU: scData = bus.num1 - bus.num2;
      OP_AND:  scData = bus.num1 & bus.num2;
      OP_OR:   scData = bus.num1 | bus.num2;
      OP_XOR:  scData = bus.num1 ^ bus.num2;
      OP_NOR:  scData = ~(bus.num1 | bus.num2);
      OP_SLL:  scData = bus.num2 << shamt;
      OP_SRL:  scData = bus.num2 >> shamt;
      OP_SRA:  scData = $signed(bus.num2) >>> shamt;
      OP_SLT:  scData = {{(WIDTH-1){1'b0}}, $signed(bus.num1) < $signed(bus.num2)};
      OP_SLTU: scData = {{(WIDTH-1){1'b0}}, bus.num1 < bus.num2};
      OP_LINK: scData = bus.linkAddr;
      OP_MUL:  scData = bus.num1 * bus.num2;
      OP_MFHI: scData = hiReg;
      OP_MFLO: scData = loReg;
      default: scWen  = 1'b0;
    endcase
    if (scOvf) scWen = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hiReg              <= '0;
      loReg              <= '0;
      bus.out_valid      <= 1'b0;
      bus.RegWriteEn_o   <= 1'b0;
      bus.RegWriteAddr_o <= '0;
      bus.RegWriteData_o <= '0;
      bus.overflow_o     <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid    <= 1'b0;
      bus.RegWriteEn_o <= 1'b0;
    end else if (mdDone) begin
      hiReg            <= mdHi;
      loReg            <= mdLo;
      bus.out_valid    <= 1'b1;
      bus.RegWriteEn_o <= 1'b0;
      bus.overflow_o   <= 1'b0;
    end else if (accept) begin
      bus.RegWriteAddr_o <= bus.RegWriteAddr_i;
      if (isMulDiv) begin
        bus.out_valid    <= 1'b0;
        bus.RegWriteEn_o <= 1'b0;
      end else begin
        bus.out_valid      <= 1'b1;
        bus.RegWriteEn_o   <= scWen;
        bus.RegWriteData_o <= scData;
        bus.overflow_o     <= scOvf;
      end
    end else begin
      bus.out_valid    <= 1'b0;
      bus.RegWriteEn_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int passCnt = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq_if #(.WIDTH(32), .OP_W(5)) bus();

  alu_muldiv_seq #(.WIDTH(32), .SHAMT_W(5), .OP_W(5)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.AluOp    = op;
    bus.num1     = a;
    bus.num2     = b;
  endtask

  task automatic single(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    drive(op, a, b);
    step();
    bus.in_valid = 1'b0;
  endtask

  // Steps until busy_o drops; cycles = edges after the accept edge.
  task automatic waitIdle(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (bus.busy_o && cycles < 100);
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.flush = 0; bus.AluOp = '0; bus.num1 = '0; bus.num2 = '0;
    bus.linkAddr = 32'h0000_1234; bus.RegWriteEn_i = 1; bus.RegWriteAddr_i = 5'd9;
    rstn = 0;
    step(); step();
    totalCnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.out_valid); else passCnt++;
    totalCnt++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy_o); else passCnt++;
    totalCnt++; if (bus.RegWriteData_o !== 32'h0) $display("FAIL reset_data got %h want 0", bus.RegWriteData_o); else passCnt++;
    totalCnt++; if (bus.RegWriteEn_o !== 1'b0 || bus.overflow_o !== 1'b0) $display("FAIL reset_wen_ovf got %b%b want 00", bus.RegWriteEn_o, bus.overflow_o); else passCnt++;
    rstn = 1;
    step();
  endtask

  task automatic test_add_overflow();
    single(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    totalCnt++; if (bus.RegWriteData_o !== 32'h8000_0000) $display("FAIL add_data got %h want 80000000", bus.RegWriteData_o); else passCnt++;
    totalCnt++; if (bus.overflow_o !== 1'b1 || bus.RegWriteEn_o !== 1'b0 || bus.out_valid !== 1'b1) $display("FAIL add_ovf got ovf=%b wen=%b vld=%b want 1 0 1", bus.overflow_o, bus.RegWriteEn_o, bus.out_valid); else passCnt++;
    single(OP_ADDU, 32'h7FFF_FFFF, 32'h1);
    totalCnt++; if (bus.RegWriteData_o !== 32'h8000_0000) $display("FAIL addu_data got %h want 80000000", bus.RegWriteData_o); else passCnt++;
    totalCnt++; if (bus.overflow_o !== 1'b0 || bus.RegWriteEn_o !== 1'b1 || bus.RegWriteAddr_o !== 5'd9) $display("FAIL addu_wen got ovf=%b wen=%b addr=%0d want 0 1 9", bus.overflow_o, bus.RegWriteEn_o, bus.RegWriteAddr_o); else passCnt++;
    step();
    totalCnt++; if (bus.out_valid !== 1'b0 || bus.RegWriteEn_o !== 1'b0 || bus.RegWriteData_o !== 32'h8000_0000) $display("FAIL idle_hold got vld=%b wen=%b data=%h want 0 0 80000000", bus.out_valid, bus.RegWriteEn_o, bus.RegWriteData_o); else passCnt++;
    single(OP_SUB, 32'h8000_0000, 32'h1);
    totalCnt++; if (bus.RegWriteData_o !== 32'h7FFF_FFFF || bus.overflow_o !== 1'b1) $display("FAIL sub_ovf got %h ovf=%b want 7fffffff 1", bus.RegWriteData_o, bus.overflow_o); else passCnt++;
    single(OP_MUL, 32'h0001_0000, 32'h0001_0001);
    totalCnt++; if (bus.RegWriteData_o !== 32'h0001_0000 || bus.RegWriteEn_o !== 1'b1) $display("FAIL mul_low got %h wen=%b want 00010000 1", bus.RegWriteData_o, bus.RegWriteEn_o); else passCnt++;
    single(OP_LINK, 32'h0, 32'h0);
    totalCnt++; if (bus.RegWriteData_o !== 32'h0000_1234) $display("FAIL link got %h want 00001234", bus.RegWriteData_o); else passCnt++;
  endtask

  task automatic test_shift_slt();
    single(OP_SRA, 32'd4, 32'hF000_0000);
    totalCnt++; if (bus.RegWriteData_o !== 32'hFF00_0000) $display("FAIL sra got %h want ff000000", bus.RegWriteData_o); else passCnt++;
    single(OP_SRL, 32'd4, 32'hF000_0000);
    totalCnt++; if (bus.RegWriteData_o !== 32'h0F00_0000) $display("FAIL srl got %h want 0f000000", bus.RegWriteData_o); else passCnt++;
    single(OP_SLL, 32'd33, 32'h0000_0003);
    totalCnt++; if (bus.RegWriteData_o !== 32'h0000_0006) $display("FAIL sll_shamt got %h want 00000006", bus.RegWriteData_o); else passCnt++;
    single(OP_SLT, 32'hFFFF_FFFF, 32'h1);
    totalCnt++; if (bus.RegWriteData_o !== 32'h1) $display("FAIL slt got %h want 1", bus.RegWriteData_o); else passCnt++;
    single(OP_SLTU, 32'hFFFF_FFFF, 32'h1);
    totalCnt++; if (bus.RegWriteData_o !== 32'h0) $display("FAIL sltu got %h want 0", bus.RegWriteData_o); else passCnt++;
    single(OP_NOR, 32'h0F0F_0000, 32'h0000_00FF);
    totalCnt++; if (bus.RegWriteData_o !== 32'hF0F0_FF00) $display("FAIL nor got %h want f0f0ff00", bus.RegWriteData_o); else passCnt++;
  endtask

  task automatic test_mult();
    int cyc;
    drive(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    step(); bus.in_valid = 0;
    totalCnt++; if (bus.busy_o !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL mult_start got busy=%b vld=%b want 1 0", bus.busy_o, bus.out_valid); else passCnt++;
    waitIdle(cyc);
    totalCnt++; if (cyc != 33) $display("FAIL mult_busy_cycles got %0d want 33", cyc); else passCnt++;
    totalCnt++; if (bus.out_valid !== 1'b1 || bus.RegWriteEn_o !== 1'b0) $display("FAIL mult_done got vld=%b wen=%b want 1 0", bus.out_valid, bus.RegWriteEn_o); else passCnt++;
    single(OP_MFLO, 32'h0, 32'h0);
    totalCnt++; if (bus.RegWriteData_o !== 32'hFFFF_FFEB || bus.RegWriteEn_o !== 1'b1) $display("FAIL mult_lo got %h wen=%b want ffffffeb 1", bus.RegWriteData_o, bus.RegWriteEn_o); else passCnt++;
    single(OP_MFHI, 32'h0, 32'h0);
    totalCnt++; if (bus.RegWriteData_o !== 32'hFFFF_FFFF) $display("FAIL mult_hi got %h want ffffffff", bus.RegWriteData_o); else passCnt++;
    drive(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(); bus.in_valid = 0;
    waitIdle(cyc);
    single(OP_MFLO, 32'h0, 32'h0);
    totalCnt++; if (bus.RegWriteData_o !== 32'h0000_0001) $display("FAIL multu_lo got %h want 00000001", bus.RegWriteData_o); else passCnt++;
    single(OP_MFHI, 32'h0, 32'h0);
    totalCnt++; if (bus.RegWriteData_o !== 32'hFFFF_FFFE) $display("FAIL multu_hi got %h want fffffffe", bus.RegWriteData_o); else passCnt++;
  endtask

  task automatic test_div();
    int cyc;
    drive(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    step(); bus.in_valid = 0;
    waitIdle(cyc);
    totalCnt++; if (cyc != 33) $display("FAIL div_busy_cycles got %0d want 33", cyc); else passCnt++;
    single(OP_MFLO, 32'h0, 32'h0);
    totalCnt++; if (bus.RegWriteData_o !== 32'hFFFF_FFFD) $display("FAIL div_lo got %h want fffffffd", bus.RegWriteData_o); else passCnt++;
    single(OP_MFHI, 32'h0, 32'h0);
    totalCnt++; if (bus.RegWriteData_o !== 32'hFFFF_FFFF) $display("FAIL div_hi got %h want ffffffff", bus.RegWriteData_o); else passCnt++;

    drive(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    step(); bus.in_valid = 0;
    waitIdle(cyc);
    single(OP_MFLO, 32'h0, 32'h0);
    totalCnt++; if (bus.RegWriteData_o !== 32'hFFFF_FFFD) $display("FAIL div_negdivisor_lo got %h want fffffffd", bus.RegWriteData_o); else passCnt++;
    single(OP_MFHI, 32'h0, 32'h0);
    totalCnt++; if (bus.RegWriteData_o !== 32'h0000_0001) $display("FAIL div_negdivisor_hi got %h want 00000001", bus.RegWriteData_o); else passCnt++;

    drive(OP_DIVU, 32'd7, 32'd0);
    step(); bus.in_valid = 0;
    waitIdle(cyc);
    totalCnt++; if (cyc != 1 || bus.out_valid !== 1'b1) $display("FAIL divzero_latency got cycles=%0d vld=%b want 1 1", cyc, bus.out_valid); else passCnt++;
    single(OP_MFLO, 32'h0, 32'h0);
    totalCnt++; if (bus.RegWriteData_o !== 32'hFFFF_FFFF) $display("FAIL divzero_lo got %h want ffffffff", bus.RegWriteData_o); else passCnt++;
    single(OP_MFHI, 32'h0, 32'h0);
    totalCnt++; if (bus.RegWriteData_o !== 32'h0000_0007) $display("FAIL divzero_hi got %h want 00000007", bus.RegWriteData_o); else passCnt++;

    drive(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    step(); bus.in_valid = 0;
    waitIdle(cyc);
    single(OP_MFLO, 32'h0, 32'h0);
    totalCnt++; if (bus.RegWriteData_o !== 32'h8000_0000 || bus.overflow_o !== 1'b0) $display("FAIL divmin_lo got %h ovf=%b want 80000000 0", bus.RegWriteData_o, bus.overflow_o); else passCnt++;
    single(OP_MFHI, 32'h0, 32'h0);
    totalCnt++; if (bus.RegWriteData_o !== 32'h0) $display("FAIL divmin_hi got %h want 0", bus.RegWriteData_o); else passCnt++;

    drive(OP_DIVU, 32'd100, 32'd7);
    step(); bus.in_valid = 0;
    waitIdle(cyc);
    single(OP_MFLO, 32'h0, 32'h0);
    totalCnt++; if (bus.RegWriteData_o !== 32'd14) $display("FAIL divu_lo got %0d want 14", bus.RegWriteData_o); else passCnt++;
    single(OP_MFHI, 32'h0, 32'h0);
    totalCnt++; if (bus.RegWriteData_o !== 32'd2) $display("FAIL divu_hi got %0d want 2", bus.RegWriteData_o); else passCnt++;
  endtask

  task automatic test_busy_hold();
    int cyc;
    drive(OP_MULTU, 32'd2, 32'd3);
    step();
    drive(OP_ADD, 32'd5, 32'd6);
    waitIdle(cyc);
    totalCnt++; if (cyc != 33 || bus.out_valid !== 1'b1 || bus.RegWriteEn_o !== 1'b0) $display("FAIL hold_muldone got cycles=%0d vld=%b wen=%b want 33 1 0", cyc, bus.out_valid, bus.RegWriteEn_o); else passCnt++;
    step(); bus.in_valid = 0;
    totalCnt++; if (bus.RegWriteData_o !== 32'd11 || bus.out_valid !== 1'b1 || bus.RegWriteEn_o !== 1'b1) $display("FAIL hold_add got %0d vld=%b wen=%b want 11 1 1", bus.RegWriteData_o, bus.out_valid, bus.RegWriteEn_o); else passCnt++;
    step();
    totalCnt++; if (bus.out_valid !== 1'b0) $display("FAIL hold_single_pulse got vld=%b want 0", bus.out_valid); else passCnt++;
    single(OP_MFLO, 32'h0, 32'h0);
    totalCnt++; if (bus.RegWriteData_o !== 32'd6) $display("FAIL hold_lo got %0d want 6", bus.RegWriteData_o); else passCnt++;
  endtask

  task automatic test_flush();
    drive(OP_DIVU, 32'd1000, 32'd3);
    step(); bus.in_valid = 0;
    repeat (9) step();
    bus.flush = 1;
    step();
    bus.flush = 0;
    totalCnt++; if (bus.busy_o !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL flush_idle got busy=%b vld=%b want 0 0", bus.busy_o, bus.out_valid); else passCnt++;
    repeat (30) step();
    totalCnt++; if (bus.out_valid !== 1'b0) $display("FAIL flush_no_late_done got vld=%b want 0", bus.out_valid); else passCnt++;
    single(OP_MFLO, 32'h0, 32'h0);
    totalCnt++; if (bus.RegWriteData_o !== 32'd6) $display("FAIL flush_lo_kept got %0d want 6", bus.RegWriteData_o); else passCnt++;
    single(OP_MFHI, 32'h0, 32'h0);
    totalCnt++; if (bus.RegWriteData_o !== 32'd0) $display("FAIL flush_hi_kept got %0d want 0", bus.RegWriteData_o); else passCnt++;
    drive(OP_ADD, 32'd1, 32'd2);
    bus.flush = 1;
    step();
    bus.flush = 0; bus.in_valid = 0;
    totalCnt++; if (bus.out_valid !== 1'b0 || bus.RegWriteEn_o !== 1'b0) $display("FAIL flush_wins got vld=%b wen=%b want 0 0", bus.out_valid, bus.RegWriteEn_o); else passCnt++;
  endtask

  task automatic test_undefined();
    single(OP_ADD, 32'd1, 32'd1);
    single(5'd31, 32'd5, 32'd6);
    totalCnt++; if (bus.out_valid !== 1'b1 || bus.RegWriteEn_o !== 1'b0 || bus.RegWriteData_o !== 32'h0) $display("FAIL undef_op got vld=%b wen=%b data=%h want 1 0 0", bus.out_valid, bus.RegWriteEn_o, bus.RegWriteData_o); else passCnt++;
  endtask

  task automatic test_async_reset();
    single(OP_ADD, 32'd1, 32'd2);
    drive(OP_MULT, 32'd5, 32'd5);
    step(); bus.in_valid = 0;
    repeat (5) step();
    #2 rstn = 0;
    #1;
    totalCnt++; if (bus.busy_o !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL areset_busy got busy=%b vld=%b want 0 0", bus.busy_o, bus.out_valid); else passCnt++;
    totalCnt++; if (bus.RegWriteData_o !== 32'h0 || bus.RegWriteAddr_o !== 5'd0) $display("FAIL areset_data got %h addr=%0d want 0 0", bus.RegWriteData_o, bus.RegWriteAddr_o); else passCnt++;
    rstn = 1;
    step();
    single(OP_MFLO, 32'h0, 32'h0);
    totalCnt++; if (bus.RegWriteData_o !== 32'h0 || bus.out_valid !== 1'b1) $display("FAIL areset_lo got %h vld=%b want 0 1", bus.RegWriteData_o, bus.out_valid); else passCnt++;
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_shift_slt();
    test_mult();
    test_div();
    test_busy_hold();
    test_flush();
    test_undefined();
    test_async_reset();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
